// File: rtl/lsq.sv
// Load/store queue: buffers execute-stage memory ops in program order, issues them one at a
// time on the data bus, and returns aligned/extended load data through a write-back handshake.
module lsq #(
  parameter int C_XLEN  = 32,
  parameter int C_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              clk_en_i,
  input  logic              ex_lq_wr_i,
  input  logic              ex_sq_wr_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_regd_addr_i,
  input  logic [C_XLEN-1:0] ex_regs2_data_i,
  input  logic [C_XLEN-1:0] ex_addr_i,
  output logic              ex_full_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic              misalign_o,
  output logic              dmem_req_o,
  input  logic              dmem_ack_i,
  output logic              dmem_we_o,
  output logic [C_XLEN-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [C_XLEN-1:0] dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [C_XLEN-1:0] dmem_rdata_i,
  output logic              wb_regd_wr_o,
  output logic [4:0]        wb_regd_addr_o,
  output logic [C_XLEN-1:0] wb_regd_data_o,
  input  logic              wb_ack_i
);

  localparam int AW = $clog2(C_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(C_DEPTH);
  localparam logic [CW-1:0] SLACK_CNT = CW'(C_DEPTH - 1);

  typedef struct packed {
    logic              is_store;
    logic [2:0]        funct3;
    logic [4:0]        regd;
    logic [C_XLEN-1:0] data;
    logic [C_XLEN-1:0] addr;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t          state;
  entry_t          mem [C_DEPTH];
  entry_t          head;
  entry_t          push_entry;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            push_req;
  logic            push_ok;
  logic            push_drop;
  logic            pop;

  logic [1:0]        head_size;
  logic [1:0]        head_lane;
  logic              head_misaligned;
  logic [3:0]        head_be;
  logic [C_XLEN-1:0] head_wdata;
  logic [C_XLEN-1:0] rd_shifted;
  logic [C_XLEN-1:0] load_data;

  assign head = mem[rd_ptr];

  assign push_entry = '{
    is_store: ex_sq_wr_i,
    funct3:   ex_funct3_i,
    regd:     ex_regd_addr_i,
    data:     ex_regs2_data_i,
    addr:     ex_addr_i
  };

  // Handshakes: a bus request transfers on the first enabled edge with dmem_req_o && dmem_ack_i,
  // and the write-back on the first enabled edge with wb_regd_wr_o && wb_ack_i; until then the
  // request and all its payload stay constant. dmem_rvalid_i is a one-shot strobe honoured only in WAIT.
  always_comb begin
    pop = 1'b0;
    if (clk_en_i) begin
      case (state)
        S_REQ:   pop = head_misaligned || (dmem_ack_i && head.is_store);
        S_WAIT:  pop = dmem_rvalid_i;
        default: pop = 1'b0;
      endcase
    end
  end

  // A full queue still accepts a push when the head is leaving on the same edge.
  assign push_req  = clk_en_i && (ex_lq_wr_i || ex_sq_wr_i);
  assign push_ok   = push_req && ((count != FULL_CNT) || pop);
  assign push_drop = push_req && (count == FULL_CNT) && !pop;

  assign ex_full_o = (count >= SLACK_CNT);
  assign busy_o    = (count != '0) || (state != S_IDLE);

  // funct3[1:0]: 00 byte, 01 halfword, 1x word (covers the unused 011/110/111 encodings).
  always_comb begin
    head_size       = head.funct3[1:0];
    head_lane       = head.addr[1:0];
    head_misaligned = 1'b0;
    head_be         = 4'b1111;
    head_wdata      = head.data;
    case (head_size)
      2'b00: begin
        head_be    = 4'b0001 << head_lane;
        head_wdata = {4{head.data[7:0]}};
      end
      2'b01: begin
        head_misaligned = head_lane[0];
        head_be         = 4'b0011 << head_lane;
        head_wdata      = {2{head.data[15:0]}};
      end
      default: begin
        head_misaligned = (head_lane != 2'b00);
        head_be         = 4'b1111;
        head_wdata      = head.data;
      end
    endcase
  end

  assign rd_shifted = dmem_rdata_i >> {head_lane, 3'b000};

  always_comb begin
    load_data = rd_shifted;
    case (head.funct3)
      3'b000:  load_data = {{(C_XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
      3'b001:  load_data = {{(C_XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
      3'b100:  load_data = {{(C_XLEN-8){1'b0}}, rd_shifted[7:0]};
      3'b101:  load_data = {{(C_XLEN-16){1'b0}}, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
  end

  // Entry storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clk_en_i) begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state          <= S_IDLE;
      ovf_o          <= 1'b0;
      misalign_o     <= 1'b0;
      dmem_req_o     <= 1'b0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_be_o      <= '0;
      dmem_wdata_o   <= '0;
      wb_regd_wr_o   <= 1'b0;
      wb_regd_addr_o <= '0;
      wb_regd_data_o <= '0;
    end else if (clk_en_i) begin
      ovf_o      <= push_drop;
      misalign_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_REQ;
            // Bus fields are loaded once here so they cannot move while the request waits.
            if (!head_misaligned) begin
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= head.is_store;
              dmem_addr_o  <= {head.addr[C_XLEN-1:2], 2'b00};
              dmem_be_o    <= head_be;
              dmem_wdata_o <= head_wdata;
            end
          end
        end
        S_REQ: begin
          if (head_misaligned) begin
            misalign_o <= 1'b1;
            state      <= S_IDLE;
          end else if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            state      <= head.is_store ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dmem_rvalid_i) begin
            wb_regd_data_o <= load_data;
            wb_regd_addr_o <= head.regd;
            if (head.regd != 5'd0) begin
              wb_regd_wr_o <= 1'b1;
              state        <= S_WB;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_WB: begin
          if (wb_ack_i) begin
            wb_regd_wr_o <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/lsq.md
# lsq

Load/store queue sitting directly downstream of the execute stage. It buffers load and store operations issued by execute in program order, performs each one on the data-memory bus with one outstanding request at a time, aligns and extends load data, and returns the loaded value to the register file through its own write-back handshake. It exports a full flag so execute can throttle issue.

## Interface
Parameters:
- C_XLEN, 32, data/address width; only 32 is supported, giving 4 byte lanes.
- C_DEPTH, 4, number of queue entries; power of two, minimum 2.

Ports:
- clk_i  in  1  clock.
- resetb_i  in  1  reset, asynchronous, active-low.
- clk_en_i  in  1  global clock enable; no state changes while low.
- ex_lq_wr_i  in  1  push a load entry.
- ex_sq_wr_i  in  1  push a store entry; never high together with ex_lq_wr_i.
- ex_funct3_i  in  3  access size/sign (LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101).
- ex_regd_addr_i  in  5  load destination register.
- ex_regs2_data_i  in  C_XLEN  store data.
- ex_addr_i  in  C_XLEN  byte address.
- ex_full_o  out  1  high when count >= C_DEPTH-1.
- busy_o  out  1  high when count != 0 or the FSM is not in IDLE.
- ovf_o  out  1  one-cycle pulse when a push is dropped because count == C_DEPTH.
- misalign_o  out  1  one-cycle pulse when the head entry is misaligned.
- dmem_req_o  out  1  bus request valid.
- dmem_ack_i  in  1  bus request accepted.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  C_XLEN  word-aligned address, i.e. {addr[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  C_XLEN  store data replicated to the selected lanes.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  C_XLEN  read word.
- wb_regd_wr_o  out  1  write-back request.
- wb_regd_addr_o  out  5  write-back register.
- wb_regd_data_o  out  C_XLEN  aligned and extended load data.
- wb_ack_i  in  1  register file accepted the write-back.

## Operation
- Circular FIFO with read pointer, write pointer and count.
  - Pointers are log2(C_DEPTH) bits and wrap naturally.
  - Count is log2(C_DEPTH)+1 bits.
  - Each entry holds: type (load/store), funct3, regd_addr, data, addr.
- A push with count == C_DEPTH is discarded and pulses ovf_o. Pointers and count are unchanged.
- A simultaneous push and pop leaves count unchanged. This is legal when full, because the pop frees a slot first.
- FSM states: IDLE, REQ, WAIT, WB.
  - IDLE: when count != 0, go to REQ.
  - REQ, head misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0):
    - dmem_req_o stays 0.
    - misalign_o pulses.
    - Head is popped; go to IDLE.
  - REQ, head aligned: dmem_req_o=1, and the address, byte enables, write enable and write data are held stable until dmem_ack_i.
    - On ack with a store: pop and go to IDLE.
    - On ack with a load: go to WAIT.
  - WAIT: on dmem_rvalid_i, the aligned data and regd_addr are registered and the head is popped.
    - regd_addr == 0: go to IDLE with no write-back.
    - Otherwise go to WB.
  - WB: wb_regd_wr_o=1 with data and address stable until wb_ack_i, then go to IDLE.
- Byte enables:
  - Byte access: 0001 << addr[1:0].
  - Halfword access: 0011 << addr[1:0].
  - Word access: 1111.
- Store data: byte stores replicate wdata[7:0] to all four lanes; halfword stores replicate wdata[15:0] to both halves.
- Load alignment: the read word is shifted right by 8*addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- funct3 values 011, 110 and 111 are treated as word access.
- dmem_rvalid_i outside WAIT is ignored.

## Timing
- Reset values:
  - All outputs are 0, except ex_full_o, which is 0 because count=0.
  - Pointers and count are 0; FSM is in IDLE.
  - Entry contents are not reset.
- Reset asserted mid-transaction aborts it immediately. Queued entries are lost, and no pending bus or write-back request survives.
- With clk_en_i low, state, pointers and outputs hold. Bus handshakes are sampled only when clk_en_i is high.
- Push at edge t:
  - Count updates at t+1.
  - FSM reaches REQ at t+2, so dmem_req_o is high in the cycle after t+1.
- Zero-wait store (ack in the first REQ cycle): popped at the end of that cycle.
- Zero-wait load (ack, then rvalid the next cycle, then wb_ack the next cycle):
  - wb_regd_wr_o is high 2 cycles after the ack cycle.
  - It drops the cycle after wb_ack_i.
- ex_full_o is combinational from count and leaves one entry of slack for execute's registered push.
- ovf_o and misalign_o are registered single-cycle pulses.

## Test plan
- SW at addr 0x100 with data 0xDEADBEEF, ack at the first request:
  - dmem_req_o=1, dmem_we_o=1, addr 0x100, be 1111, wdata 0xDEADBEEF.
  - busy_o=0 two cycles later.
- LB at addr 0x203, rdata 0x80FF_0000, regd 5:
  - be 1000, addr 0x200; write-back to x5 with 0xFFFFFF80.
  - LBU at the same address returns 0x00000080.
- Push 5 stores while dmem_ack_i=0 (C_DEPTH=4):
  - ex_full_o rises after the 3rd push.
  - The 5th push pulses ovf_o.
  - Releasing ack drains exactly 4 stores, in order.
- LH at addr 0x101:
  - misalign_o pulses and no dmem_req_o occurs.
  - The following SW still issues normally.
- LW to x0 with rdata 0x12345678: the bus read occurs; wb_regd_wr_o never asserts.
- LW with wb_ack_i held low 3 cycles: wb data/addr stay stable 4 cycles.
  - resetb_i pulsed while in WAIT: all outputs read 0 and busy_o=0 after release.
